// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Multi-cycle RV32I control sequencer. Takes the IR opcode and drives the
//   enables and mux selects of the multi-cycle datapath. Memory accesses take
//   either a fixed number of cycles (MEM_MODE=0) or last until mem_ready
//   (MEM_MODE=1). ecall with halt_cond set parks the machine in S_HALT.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   S_IF    | fetch: read mem at PC, latch IR/OldPC, PC <= PC+4
//   S_ID    | decode: ALUOut <= OldPC + imm (branch/jump target)
//   S_EX    | execute / address calculation
//   S_MEM   | data memory read (load) or write (store)
//   S_WB    | register file write-back (ALUOut or MDR)
//   S_JUMP  | JAL/JALR: rd <= PC, PC <= ALUOut
//   S_ECALL | ecall: halt if halt_cond, else treat as NOP
//   S_HALT  | terminal, all controls low until reset
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   opcode            IR[6:0]
//   halt_cond         datapath x17==10, used in S_ECALL
//   mem_ready         memory access completes (MEM_MODE=1)
//   PCWriteCond..RegWrite  datapath controls
//   is_halted         high in S_HALT
//   state_o           current state (debug)
//   instret           retired instruction count
module multicycle_ctrl_fsm #(
  parameter int MEM_MODE    = 0,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             halt_cond,
  input  logic             mem_ready,
  output logic             PCWriteCond,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       MemtoReg,
  output logic             PCSource,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             is_halted,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_JUMP  = 3'd5,
    S_ECALL = 3'd6,
    S_HALT  = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // Wait counter runs down from MEM_LATENCY-1; access completes at zero.
  localparam int WCNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(MEM_LATENCY - 1);

  state_t state, state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [CNT_W-1:0]  instret_q;
  logic              mem_done;
  logic              retire;

  logic       pcwc_c, pcw_c, iord_c, mr_c, mw_c, irw_c, pcs_c, rw_c;
  logic [1:0] m2r_c, aluop_c, asa_c, asb_c;

  assign mem_done = (MEM_MODE != 0) ? mem_ready : (wcnt == '0);

  // An instruction retires when control returns to fetch, or when ecall halts.
  assign retire = ((state != S_IF) && (state_nxt == S_IF)) ||
                  ((state == S_ECALL) && (state_nxt == S_HALT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IF;
      wcnt      <= WCNT_LOAD;
      instret_q <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wcnt <= WCNT_LOAD;
      else if (wcnt != '0)
        wcnt <= wcnt - 1'b1;
      if (retire)
        instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pcwc_c    = 1'b0;
    pcw_c     = 1'b0;
    iord_c    = 1'b0;
    mr_c      = 1'b0;
    mw_c      = 1'b0;
    irw_c     = 1'b0;
    pcs_c     = 1'b0;
    rw_c      = 1'b0;
    m2r_c     = 2'b00;
    aluop_c   = 2'b00;
    asa_c     = 2'b00;
    asb_c     = 2'b00;

    case (state)
      S_IF: begin
        mr_c  = 1'b1;
        asb_c = 2'b01;
        if (mem_done) begin
          irw_c     = 1'b1;
          pcw_c     = 1'b1;
          state_nxt = S_ID;
        end
      end
      S_ID: begin
        asa_c = 2'b10;
        asb_c = 2'b10;
        case (opcode)
          OP_ECALL: state_nxt = S_ECALL;
          OP_JAL:   state_nxt = S_JUMP;
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
          OP_JALR, OP_LUI, OP_AUIPC: state_nxt = S_EX;
          default:  state_nxt = S_IF;
        endcase
      end
      S_EX: begin
        state_nxt = S_WB;
        case (opcode)
          OP_R: begin
            asa_c = 2'b01; asb_c = 2'b00; aluop_c = 2'b10;
          end
          OP_I: begin
            asa_c = 2'b01; asb_c = 2'b10; aluop_c = 2'b10;
          end
          OP_LOAD, OP_STORE: begin
            asa_c = 2'b01; asb_c = 2'b10;
            state_nxt = S_MEM;
          end
          OP_JALR: begin
            asa_c = 2'b01; asb_c = 2'b10;
            state_nxt = S_JUMP;
          end
          OP_LUI: begin
            asa_c = 2'b11; asb_c = 2'b10;
          end
          OP_AUIPC: begin
            asa_c = 2'b10; asb_c = 2'b10;
          end
          OP_BRANCH: begin
            asa_c = 2'b01; asb_c = 2'b00; aluop_c = 2'b01;
            pcwc_c = 1'b1; pcs_c = 1'b1;
            state_nxt = S_IF;
          end
          default: state_nxt = S_IF;
        endcase
      end
      S_MEM: begin
        iord_c = 1'b1;
        if (opcode == OP_LOAD) mr_c = 1'b1;
        else                   mw_c = 1'b1;
        if (mem_done)
          state_nxt = (opcode == OP_LOAD) ? S_WB : S_IF;
      end
      S_WB: begin
        rw_c      = 1'b1;
        m2r_c     = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        state_nxt = S_IF;
      end
      S_JUMP: begin
        rw_c      = 1'b1;
        m2r_c     = 2'b10;
        pcw_c     = 1'b1;
        pcs_c     = 1'b1;
        state_nxt = S_IF;
      end
      S_ECALL: state_nxt = halt_cond ? S_HALT : S_IF;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
  end

  // Reset masks every control so an interrupted access writes nothing.
  assign PCWriteCond = pcwc_c & ~reset;
  assign PCWrite     = pcw_c  & ~reset;
  assign IorD        = iord_c & ~reset;
  assign MemRead     = mr_c   & ~reset;
  assign MemWrite    = mw_c   & ~reset;
  assign IRWrite     = irw_c  & ~reset;
  assign PCSource    = pcs_c  & ~reset;
  assign RegWrite    = rw_c   & ~reset;
  assign MemtoReg    = reset ? 2'b00 : m2r_c;
  assign ALUOp       = reset ? 2'b00 : aluop_c;
  assign ALUSrcA     = reset ? 2'b00 : asa_c;
  assign ALUSrcB     = reset ? 2'b00 : asb_c;
  assign is_halted   = ~reset & (state == S_HALT);
  assign state_o     = state;
  assign instret     = reset ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm
//   Directed bench for multicycle_ctrl_fsm. Three instances share the inputs:
//   [0] fixed latency 1, [1] ready handshake, [2] fixed latency 4.
//   sel chooses which instance the checks observe.
module tb_multicycle_ctrl_fsm;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
                         S_WB = 3'd4, S_JUMP = 3'd5, S_ECALL = 3'd6, S_HALT = 3'd7;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_ECALL = 7'b1110011, OP_BAD = 7'b1111111;

  // {PCWriteCond,PCWrite,IorD,MemRead,MemWrite,IRWrite,MemtoReg,PCSource,ALUOp,ALUSrcA,ALUSrcB,RegWrite}
  localparam logic [15:0] CW_ZERO     = 16'b0_0_0_0_0_0_00_0_00_00_00_0;
  localparam logic [15:0] CW_IF_DONE  = 16'b0_1_0_1_0_1_00_0_00_00_01_0;
  localparam logic [15:0] CW_IF_WAIT  = 16'b0_0_0_1_0_0_00_0_00_00_01_0;
  localparam logic [15:0] CW_ID       = 16'b0_0_0_0_0_0_00_0_00_10_10_0;
  localparam logic [15:0] CW_EX_R     = 16'b0_0_0_0_0_0_00_0_10_01_00_0;
  localparam logic [15:0] CW_EX_I     = 16'b0_0_0_0_0_0_00_0_10_01_10_0;
  localparam logic [15:0] CW_EX_ADDR  = 16'b0_0_0_0_0_0_00_0_00_01_10_0;
  localparam logic [15:0] CW_EX_LUI   = 16'b0_0_0_0_0_0_00_0_00_11_10_0;
  localparam logic [15:0] CW_EX_AUIPC = 16'b0_0_0_0_0_0_00_0_00_10_10_0;
  localparam logic [15:0] CW_EX_BR    = 16'b1_0_0_0_0_0_00_1_01_01_00_0;
  localparam logic [15:0] CW_MEM_LD   = 16'b0_0_1_1_0_0_00_0_00_00_00_0;
  localparam logic [15:0] CW_MEM_ST   = 16'b0_0_1_0_1_0_00_0_00_00_00_0;
  localparam logic [15:0] CW_WB_ALU   = 16'b0_0_0_0_0_0_00_0_00_00_00_1;
  localparam logic [15:0] CW_WB_LD    = 16'b0_0_0_0_0_0_01_0_00_00_00_1;
  localparam logic [15:0] CW_JUMP     = 16'b0_1_0_0_0_0_10_1_00_00_00_1;

  logic       clk, reset, halt_cond, mem_ready;
  logic [6:0] opcode;

  logic        pcwc[3], pcw[3], iord[3], mr[3], mw[3], irw[3], pcs[3], rw[3], halted[3];
  logic [1:0]  m2r[3], aluop[3], asa[3], asb[3];
  logic [2:0]  st[3];
  logic [31:0] icnt[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_ctrl_fsm #(
      .MEM_MODE   ((g == 1) ? 1 : 0),
      .MEM_LATENCY((g == 2) ? 4 : 1),
      .CNT_W      (32)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .halt_cond  (halt_cond),
      .mem_ready  (mem_ready),
      .PCWriteCond(pcwc[g]),
      .PCWrite    (pcw[g]),
      .IorD       (iord[g]),
      .MemRead    (mr[g]),
      .MemWrite   (mw[g]),
      .IRWrite    (irw[g]),
      .MemtoReg   (m2r[g]),
      .PCSource   (pcs[g]),
      .ALUOp      (aluop[g]),
      .ALUSrcA    (asa[g]),
      .ALUSrcB    (asb[g]),
      .RegWrite   (rw[g]),
      .is_halted  (halted[g]),
      .state_o    (st[g]),
      .instret    (icnt[g])
    );
  end

  logic [1:0]  sel;
  logic [15:0] obs_ctrl;
  logic [2:0]  obs_state;
  logic [31:0] obs_instret;
  logic        obs_halt;

  always_comb begin
    obs_ctrl    = {pcwc[sel], pcw[sel], iord[sel], mr[sel], mw[sel], irw[sel], m2r[sel],
                   pcs[sel], aluop[sel], asa[sel], asb[sel], rw[sel]};
    obs_state   = st[sel];
    obs_instret = icnt[sel];
    obs_halt    = halted[sel];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the current cycle's state and controls, then advance one clock.
  task automatic cyc(input string tag, input logic [2:0] es, input logic [15:0] ec);
    #1;
    chk({tag, "_st"}, {29'd0, obs_state}, {29'd0, es});
    chk({tag, "_cw"}, {16'd0, obs_ctrl}, {16'd0, ec});
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; opcode = 7'd0; halt_cond = 1'b0; mem_ready = 1'b0; sel = 2'd0;
    tick();
    tick();
    #1;
    chk("rst_cw", {16'd0, obs_ctrl}, 32'd0);
    chk("rst_instret", obs_instret, 32'd0);
    chk("rst_halted", {31'd0, obs_halt}, 32'd0);
    reset = 1'b0;

    // T1: add on latency-1 instance
    opcode = OP_R;
    cyc("t1_if", S_IF, CW_IF_DONE);
    cyc("t1_id", S_ID, CW_ID);
    cyc("t1_ex", S_EX, CW_EX_R);
    cyc("t1_wb", S_WB, CW_WB_ALU);
    chk("t1_instret", obs_instret, 32'd1);

    // T3: beq then sw
    opcode = OP_BRANCH;
    cyc("t3_br_if", S_IF, CW_IF_DONE);
    cyc("t3_br_id", S_ID, CW_ID);
    cyc("t3_br_ex", S_EX, CW_EX_BR);
    chk("t3_br_instret", obs_instret, 32'd2);
    opcode = OP_STORE;
    cyc("t3_sw_if", S_IF, CW_IF_DONE);
    cyc("t3_sw_id", S_ID, CW_ID);
    cyc("t3_sw_ex", S_EX, CW_EX_ADDR);
    cyc("t3_sw_mem", S_MEM, CW_MEM_ST);
    chk("t3_sw_instret", obs_instret, 32'd3);

    // T4: JAL then JALR
    opcode = OP_JAL;
    cyc("t4_jal_if", S_IF, CW_IF_DONE);
    cyc("t4_jal_id", S_ID, CW_ID);
    cyc("t4_jal_j", S_JUMP, CW_JUMP);
    opcode = OP_JALR;
    cyc("t4_jalr_if", S_IF, CW_IF_DONE);
    cyc("t4_jalr_id", S_ID, CW_ID);
    cyc("t4_jalr_ex", S_EX, CW_EX_ADDR);
    cyc("t4_jalr_j", S_JUMP, CW_JUMP);
    chk("t4_instret", obs_instret, 32'd5);

    // Remaining EX paths, load on fixed latency, unknown opcode as NOP
    opcode = OP_LUI;
    cyc("lui_if", S_IF, CW_IF_DONE);
    cyc("lui_id", S_ID, CW_ID);
    cyc("lui_ex", S_EX, CW_EX_LUI);
    cyc("lui_wb", S_WB, CW_WB_ALU);
    opcode = OP_AUIPC;
    cyc("auipc_if", S_IF, CW_IF_DONE);
    cyc("auipc_id", S_ID, CW_ID);
    cyc("auipc_ex", S_EX, CW_EX_AUIPC);
    cyc("auipc_wb", S_WB, CW_WB_ALU);
    opcode = OP_I;
    cyc("addi_if", S_IF, CW_IF_DONE);
    cyc("addi_id", S_ID, CW_ID);
    cyc("addi_ex", S_EX, CW_EX_I);
    cyc("addi_wb", S_WB, CW_WB_ALU);
    opcode = OP_LOAD;
    cyc("lw0_if", S_IF, CW_IF_DONE);
    cyc("lw0_id", S_ID, CW_ID);
    cyc("lw0_ex", S_EX, CW_EX_ADDR);
    cyc("lw0_mem", S_MEM, CW_MEM_LD);
    cyc("lw0_wb", S_WB, CW_WB_LD);
    opcode = OP_BAD;
    cyc("nop_if", S_IF, CW_IF_DONE);
    cyc("nop_id", S_ID, CW_ID);
    chk("nop_instret", obs_instret, 32'd10);

    // T5: ecall continue, then ecall halt
    opcode = OP_ECALL; halt_cond = 1'b0;
    cyc("t5a_if", S_IF, CW_IF_DONE);
    cyc("t5a_id", S_ID, CW_ID);
    cyc("t5a_ecall", S_ECALL, CW_ZERO);
    chk("t5a_instret", obs_instret, 32'd11);
    halt_cond = 1'b1;
    cyc("t5b_if", S_IF, CW_IF_DONE);
    cyc("t5b_id", S_ID, CW_ID);
    cyc("t5b_ecall", S_ECALL, CW_ZERO);
    chk("t5b_instret", obs_instret, 32'd12);
    for (int i = 0; i < 12; i++) begin
      opcode    = (i % 2 == 0) ? OP_R : OP_LOAD;
      mem_ready = i[0];
      chk("t5_halted", {31'd0, obs_halt}, 32'd1);
      cyc("t5_halt", S_HALT, CW_ZERO);
    end
    chk("t5_instret_hold", obs_instret, 32'd12);
    halt_cond = 1'b0;

    // T2: ready-handshake lw with 3 wait cycles in S_MEM
    sel = 2'd1; mem_ready = 1'b0;
    do_reset();
    opcode = OP_LOAD;
    cyc("t2_if_wait", S_IF, CW_IF_WAIT);
    mem_ready = 1'b1;
    cyc("t2_if", S_IF, CW_IF_DONE);
    cyc("t2_id", S_ID, CW_ID);
    mem_ready = 1'b0;
    cyc("t2_ex", S_EX, CW_EX_ADDR);
    for (int i = 0; i < 3; i++) cyc("t2_mem_wait", S_MEM, CW_MEM_LD);
    mem_ready = 1'b1;
    cyc("t2_mem_done", S_MEM, CW_MEM_LD);
    mem_ready = 1'b0;
    cyc("t2_wb", S_WB, CW_WB_LD);
    chk("t2_instret", obs_instret, 32'd1);
    cyc("t2_back_if", S_IF, CW_IF_WAIT);

    // T6: latency-4 instance, reset in the middle of a load access
    sel = 2'd2;
    do_reset();
    opcode = OP_R;
    for (int i = 0; i < 3; i++) cyc("t6_add_if_wait", S_IF, CW_IF_WAIT);
    cyc("t6_add_if", S_IF, CW_IF_DONE);
    cyc("t6_add_id", S_ID, CW_ID);
    cyc("t6_add_ex", S_EX, CW_EX_R);
    cyc("t6_add_wb", S_WB, CW_WB_ALU);
    chk("t6_add_instret", obs_instret, 32'd1);
    opcode = OP_LOAD;
    for (int i = 0; i < 3; i++) cyc("t6_lw_if_wait", S_IF, CW_IF_WAIT);
    cyc("t6_lw_if", S_IF, CW_IF_DONE);
    cyc("t6_lw_id", S_ID, CW_ID);
    cyc("t6_lw_ex", S_EX, CW_EX_ADDR);
    cyc("t6_lw_mem1", S_MEM, CW_MEM_LD);
    reset = 1'b1;
    #1;
    chk("t6_rst_st", {29'd0, obs_state}, {29'd0, S_MEM});
    chk("t6_rst_cw", {16'd0, obs_ctrl}, 32'd0);
    chk("t6_rst_instret", obs_instret, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_post_st", {29'd0, obs_state}, {29'd0, S_IF});
    chk("t6_post_instret", obs_instret, 32'd0);
    cyc("t6_post_if_wait", S_IF, CW_IF_WAIT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
